pipe_dest_tracker: RTL and testbench
====================================

PIPE_DEST_TRACKER -- requirements
Module: pipe_dest_tracker

Interface
REQ-001 SHALL have port clk, input, 1, the single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port freeze, input, 1: global pipeline hold, e.g. memory wait.
REQ-004 SHALL have port flush, input, 1: branch taken, so the ID-stage instruction is discarded.
REQ-005 SHALL have port hazard_detected, input, 1: stall request from hazard detection.
REQ-006 SHALL have port id_valid, input, 1: the ID stage holds a real instruction.
REQ-007 SHALL have port id_dest, input, 4: destination register of the ID instruction.
REQ-008 SHALL have port id_WB_en, input, 1: the ID instruction writes the register file.
REQ-009 SHALL have port id_MEM_R_en, input, 1: the ID instruction is a load.
REQ-010 SHALL have ports EXE_dest, output, 4; EXE_WB_en, output, 1; EXE_MEM_R_en, output, 1: EXE-stage tag.
REQ-011 SHALL have ports MEM_dest, output, 4 and MEM_WB_en, output, 1: MEM-stage tag.
REQ-012 SHALL have ports WB_dest, output, 4 and WB_WB_en, output, 1: WB-stage tag.
REQ-013 SHALL have port stall_if_id, output, 1: hold the PC and the IF/ID register.
REQ-014 SHALL have port hazard_timeout, output, 1: sticky error flag for a stall that never resolves.
REQ-015 SHALL have port stall_cycles, output, 16: count of stall cycles, used only under REQ-030.

Function
REQ-016 SHALL keep a 3-entry tag pipeline (EXE, MEM, WB); each entry holds {dest[3:0], WB_en, MEM_R_en}, with MEM_R_en kept only in EXE.
REQ-017 SHALL define a bubble as dest=0, WB_en=0, MEM_R_en=0.
REQ-018 SHALL, on each rising edge with rst=0 and freeze=0, shift the pipeline: WB<=MEM, MEM<=EXE.
REQ-019 SHALL, on the same edge, load EXE with a bubble if flush=1, or hazard_detected=1, or id_valid=0; otherwise with {id_dest, id_WB_en, id_MEM_R_en}.
REQ-020 SHALL hold all three entries unchanged on any edge with freeze=1; flush and hazard_detected are ignored on that edge, and the requester must hold them.
REQ-021 SHALL treat flush=1 and hazard_detected=1 on the same cycle as a single bubble insertion.
REQ-022 SHALL drive stall_if_id = hazard_detected AND NOT flush, combinationally with zero latency.
REQ-023 SHALL drive all tag outputs directly from registers, so new values are visible one cycle after the capturing edge.
REQ-024 SHALL keep a 2-bit saturating counter of consecutive unfrozen cycles with hazard_detected=1; an unfrozen cycle with hazard_detected=0 clears it, and a frozen cycle holds it.
REQ-025 SHALL set hazard_timeout on the edge at which the counter would reach 3, i.e. the 3rd consecutive unfrozen hazard cycle; the flag then stays set until rst.
REQ-026 SHALL NOT let flush clear the timeout counter unless hazard_detected=0 on that cycle.

Reset
REQ-027 SHALL, on an edge with rst=1, load a bubble into all three entries, clear the timeout counter, clear hazard_timeout, and clear stall_cycles; rst overrides freeze, flush and hazard_detected.
REQ-028 SHALL, when rst is asserted mid-stall or mid-freeze, leave no residual tag; the first edge after rst deasserts behaves as REQ-018/019.

Configuration
REQ-029 SHALL compile the stall_cycles counter only when the macro PIPE_STALL_COUNTER_EN is defined.
REQ-030 SHALL, with PIPE_STALL_COUNTER_EN defined, increment stall_cycles on every edge with rst=0, freeze=0 and stall_if_id=1, saturating at 16'hFFFF.
REQ-031 SHALL, without PIPE_STALL_COUNTER_EN, drive stall_cycles constant 0 with no counter register.

Verification
REQ-032 SHALL cover basic flow: after rst, id_valid=1, id_dest=5, id_WB_en=1 -> EXE_dest=5 after edge 1, MEM_dest=5 after edge 2, WB_dest=5 after edge 3, with WB_en=1 throughout.
REQ-033 SHALL cover load-use: EXE holds {dest=3, MEM_R_en=1}, then hazard_detected=1 for one cycle -> stall_if_id=1, EXE becomes a bubble and MEM_dest=3 on the next edge.
REQ-034 SHALL cover flush with hazard: flush=1 and hazard_detected=1 together -> stall_if_id=0, one bubble inserted, and stall_cycles unchanged.
REQ-035 SHALL cover freeze: freeze=1 for 4 cycles with id_dest=7 presented -> all tags and stall_cycles frozen; after release, EXE_dest=7 following one edge.
REQ-036 SHALL cover timeout: hazard_detected=1 for 3 unfrozen cycles -> hazard_timeout=1 after edge 3 and it stays set; a freeze cycle inserted in the middle delays the flag by one cycle; rst clears it.
REQ-037 SHALL cover saturation (macro defined): preload stall_cycles to 16'hFFFE and apply 3 stall cycles -> the reading is 16'hFFFF and stays there.

Source files
------------

// File: rtl/pipe_dest_tracker_if.sv
// Signal bundle between the pipeline control logic and pipe_dest_tracker:
// stage hold/flush/stall requests, the ID-stage tag, and the per-stage tag outputs.
interface pipe_dest_tracker_if;
    logic        freeze;
    logic        flush;
    logic        hazard_detected;
    logic        id_valid;
    logic [3:0]  id_dest;
    logic        id_WB_en;
    logic        id_MEM_R_en;

    logic [3:0]  EXE_dest;
    logic        EXE_WB_en;
    logic        EXE_MEM_R_en;
    logic [3:0]  MEM_dest;
    logic        MEM_WB_en;
    logic [3:0]  WB_dest;
    logic        WB_WB_en;
    logic        stall_if_id;
    logic        hazard_timeout;
    logic [15:0] stall_cycles;

    modport master (
        output freeze, flush, hazard_detected, id_valid, id_dest, id_WB_en, id_MEM_R_en,
        input  EXE_dest, EXE_WB_en, EXE_MEM_R_en, MEM_dest, MEM_WB_en,
        input  WB_dest, WB_WB_en, stall_if_id, hazard_timeout, stall_cycles
    );

    modport slave (
        input  freeze, flush, hazard_detected, id_valid, id_dest, id_WB_en, id_MEM_R_en,
        output EXE_dest, EXE_WB_en, EXE_MEM_R_en, MEM_dest, MEM_WB_en,
        output WB_dest, WB_WB_en, stall_if_id, hazard_timeout, stall_cycles
    );
endinterface

// File: rtl/pipe_dest_tracker.sv
// Destination-tag pipeline (EXE/MEM/WB) with stall control and a sticky stall-timeout flag.
// Optional stall-cycle counter is built only when PIPE_STALL_COUNTER_EN is defined.
//
// Timeout FSM (counts consecutive unfrozen hazard cycles):
//   state  | meaning
//   HZ_CLR | no hazard in the last unfrozen cycle
//   HZ_ONE | one consecutive hazard cycle
//   HZ_TWO | two consecutive hazard cycles
//   HZ_SAT | three or more; hazard_timeout has been raised
module pipe_dest_tracker (
    input logic               clk,
    input logic               rst,
    pipe_dest_tracker_if.slave bus
);

    typedef enum logic [1:0] {
        HZ_CLR = 2'd0,
        HZ_ONE = 2'd1,
        HZ_TWO = 2'd2,
        HZ_SAT = 2'd3
    } hz_state_t;

    hz_state_t  hz_state;
    hz_state_t  hz_state_nxt;
    logic       timeout_set;
    logic       timeout_q;

    logic [3:0] exe_dest;
    logic       exe_wb_en;
    logic       exe_mem_r_en;
    logic [3:0] mem_dest;
    logic       mem_wb_en;
    logic [3:0] wb_dest;
    logic       wb_wb_en;

    logic       advance;
    logic       bubble_in;

    assign advance   = ~bus.freeze;
    // flush and hazard together still produce exactly one bubble
    assign bubble_in = bus.flush | bus.hazard_detected | ~bus.id_valid;

    assign bus.stall_if_id = bus.hazard_detected & ~bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            exe_dest     <= 4'd0;
            exe_wb_en    <= 1'b0;
            exe_mem_r_en <= 1'b0;
            mem_dest     <= 4'd0;
            mem_wb_en    <= 1'b0;
            wb_dest      <= 4'd0;
            wb_wb_en     <= 1'b0;
        end else if (advance) begin
            wb_dest   <= mem_dest;
            wb_wb_en  <= mem_wb_en;
            mem_dest  <= exe_dest;
            mem_wb_en <= exe_wb_en;
            if (bubble_in) begin
                exe_dest     <= 4'd0;
                exe_wb_en    <= 1'b0;
                exe_mem_r_en <= 1'b0;
            end else begin
                exe_dest     <= bus.id_dest;
                exe_wb_en    <= bus.id_WB_en;
                exe_mem_r_en <= bus.id_MEM_R_en;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hz_state  <= HZ_CLR;
            timeout_q <= 1'b0;
        end else begin
            hz_state <= hz_state_nxt;
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // A frozen cycle neither advances nor clears the count; flush alone does not clear it
    always_comb begin
        hz_state_nxt = hz_state;
        timeout_set  = 1'b0;
        if (!bus.freeze) begin
            if (bus.hazard_detected) begin
                case (hz_state)
                    HZ_CLR:  hz_state_nxt = HZ_ONE;
                    HZ_ONE:  hz_state_nxt = HZ_TWO;
                    HZ_TWO: begin
                        hz_state_nxt = HZ_SAT;
                        timeout_set  = 1'b1;
                    end
                    HZ_SAT: begin
                        hz_state_nxt = HZ_SAT;
                        timeout_set  = 1'b1;
                    end
                    default: hz_state_nxt = HZ_CLR;
                endcase
            end else begin
                hz_state_nxt = HZ_CLR;
            end
        end
    end

`ifdef PIPE_STALL_COUNTER_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (advance && bus.stall_if_id && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign bus.stall_cycles = stall_cnt;
`else
    assign bus.stall_cycles = 16'h0000;
`endif

    assign bus.EXE_dest       = exe_dest;
    assign bus.EXE_WB_en      = exe_wb_en;
    assign bus.EXE_MEM_R_en   = exe_mem_r_en;
    assign bus.MEM_dest       = mem_dest;
    assign bus.MEM_WB_en      = mem_wb_en;
    assign bus.WB_dest        = wb_dest;
    assign bus.WB_WB_en       = wb_wb_en;
    assign bus.hazard_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_dest_tracker.sv
// Scoreboard bench for pipe_dest_tracker: expected post-edge snapshots are queued
// as stimulus is applied and compared one time unit after the capturing edge.
module tb_pipe_dest_tracker;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_dest_tracker_if bus ();

    pipe_dest_tracker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef PIPE_STALL_COUNTER_EN
    localparam bit SC_EN = 1'b1;
`else
    localparam bit SC_EN = 1'b0;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic        exp_to;
    logic [15:0] exp_sc;
    logic [32:0] sb[$];
    logic [32:0] got;
    logic [32:0] exp;

    function automatic logic [32:0] obs();
        return {bus.EXE_dest, bus.EXE_WB_en, bus.EXE_MEM_R_en, bus.MEM_dest, bus.MEM_WB_en,
                bus.WB_dest, bus.WB_WB_en, bus.hazard_timeout, bus.stall_cycles};
    endfunction

    function automatic logic [32:0] mk(input logic [3:0] ed, input logic ew, input logic er,
                                       input logic [3:0] md, input logic mw,
                                       input logic [3:0] wd, input logic ww);
        return {ed, ew, er, md, mw, wd, ww, exp_to, (SC_EN ? exp_sc : 16'h0000)};
    endfunction

    task automatic drive(input logic f, input logic fl, input logic hz, input logic v,
                         input logic [3:0] d, input logic w, input logic r);
        bus.freeze          = f;
        bus.flush           = fl;
        bus.hazard_detected = hz;
        bus.id_valid        = v;
        bus.id_dest         = d;
        bus.id_WB_en        = w;
        bus.id_MEM_R_en     = r;
    endtask

    // Expected effect of the coming edge on the stall counter and reset-cleared flags
    task automatic model_edge();
        if (rst) begin
            exp_sc = 16'h0000;
            exp_to = 1'b0;
        end else if (!bus.freeze && bus.hazard_detected && !bus.flush && exp_sc != 16'hFFFF) begin
            exp_sc = exp_sc + 16'd1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 1, 1, 1, 4'd9, 1, 1);
        model_edge();
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tick();
        got = obs(); exp = sb.pop_front(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_basic_flow();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive(0, 0, 0, 1, 4'd5, 1, 0);
            else        drive(0, 0, 0, 0, 4'd0, 0, 0);
            model_edge();
            sb.push_back(mk((i == 0) ? 4'd5 : 4'd0, i == 0, 0,
                            (i == 1) ? 4'd5 : 4'd0, i == 1,
                            (i == 2) ? 4'd5 : 4'd0, i == 2));
            tick();
            got = obs(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL basic_flow edge %0d: got %h expected %h", i + 1, got, exp);
            end
        end
    endtask

    task automatic test_load_use();
        drive(0, 0, 0, 1, 4'd3, 1, 1);
        model_edge();
        sb.push_back(mk(4'd3, 1, 1, 0, 0, 0, 0));
        tick();
        got = obs(); exp = sb.pop_front(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL load_use load: got %h expected %h", got, exp);
        end

        drive(0, 0, 1, 1, 4'd4, 1, 0);
        #1;
        checks++;
        if (bus.stall_if_id !== 1'b1) begin
            failures++;
            $display("FAIL load_use stall_if_id: got %b expected 1", bus.stall_if_id);
        end
        model_edge();
        sb.push_back(mk(0, 0, 0, 4'd3, 1, 0, 0));
        tick();
        got = obs(); exp = sb.pop_front(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL load_use bubble: got %h expected %h", got, exp);
        end

        drive(0, 0, 0, 1, 4'd4, 1, 0);
        model_edge();
        sb.push_back(mk(4'd4, 1, 0, 0, 0, 4'd3, 1));
        tick();
        got = obs(); exp = sb.pop_front(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL load_use resume: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_flush_hazard();
        drive(0, 1, 1, 1, 4'd6, 1, 0);
        #1;
        checks++;
        if (bus.stall_if_id !== 1'b0) begin
            failures++;
            $display("FAIL flush_hazard stall_if_id: got %b expected 0", bus.stall_if_id);
        end
        model_edge();
        sb.push_back(mk(0, 0, 0, 4'd4, 1, 0, 0));
        tick();
        got = obs(); exp = sb.pop_front(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL flush_hazard bubble: got %h expected %h", got, exp);
        end

        drive(0, 0, 0, 0, 4'd0, 0, 0);
        model_edge();
        sb.push_back(mk(0, 0, 0, 0, 0, 4'd4, 1));
        tick();
        got = obs(); exp = sb.pop_front(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL flush_hazard drain: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_freeze();
        drive(0, 0, 0, 1, 4'd2, 1, 0);
        model_edge();
        sb.push_back(mk(4'd2, 1, 0, 0, 0, 0, 0));
        tick();
        got = obs(); exp = sb.pop_front(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL freeze preload: got %h expected %h", got, exp);
        end

        for (int i = 0; i < 4; i++) begin
            drive(1, i == 2, 1, 1, 4'd7, 1, 1);
            model_edge();
            sb.push_back(mk(4'd2, 1, 0, 0, 0, 0, 0));
            tick();
            got = obs(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL freeze hold %0d: got %h expected %h", i, got, exp);
            end
        end

        drive(0, 0, 0, 1, 4'd7, 1, 0);
        model_edge();
        sb.push_back(mk(4'd7, 1, 0, 4'd2, 1, 0, 0));
        tick();
        got = obs(); exp = sb.pop_front(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL freeze release: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_timeout();
        bit hz_pat [6] = '{1, 1, 0, 1, 1, 1};
        bit to_pat [6] = '{0, 0, 0, 0, 0, 1};
        // Two hazard edges, a frozen hazard edge, then the third unfrozen hazard edge
        logic [32:0] seq [6];
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin drive(0, 0, 1, 1, 4'd8, 1, 0); exp_to = 1'b0; end
                1: begin drive(0, 0, 1, 1, 4'd8, 1, 0); exp_to = 1'b0; end
                2: begin drive(1, 0, 1, 1, 4'd8, 1, 0); exp_to = 1'b0; end
                3: begin drive(0, 0, 1, 1, 4'd8, 1, 0); exp_to = 1'b1; end
                default: drive(0, 0, 0, 0, 4'd0, 0, 0);
            endcase
            model_edge();
            case (i)
                0: seq[i] = mk(0, 0, 0, 4'd7, 1, 4'd2, 1);
                1, 2: seq[i] = mk(0, 0, 0, 0, 0, 4'd7, 1);
                default: seq[i] = mk(0, 0, 0, 0, 0, 0, 0);
            endcase
            sb.push_back(seq[i]);
            tick();
            got = obs(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL timeout freeze_seq %0d: got %h expected %h", i, got, exp);
            end
        end

        rst = 1'b1;
        drive(1, 0, 1, 1, 4'd9, 1, 1);
        model_edge();
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tick();
        got = obs(); exp = sb.pop_front(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL timeout rst_clear: got %h expected %h", got, exp);
        end

        rst = 1'b0;
        drive(0, 0, 0, 1, 4'd9, 1, 1);
        model_edge();
        sb.push_back(mk(4'd9, 1, 1, 0, 0, 0, 0));
        tick();
        got = obs(); exp = sb.pop_front(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL timeout post_rst: got %h expected %h", got, exp);
        end

        for (int i = 0; i < 6; i++) begin
            drive(0, 0, hz_pat[i], 0, 4'd0, 0, 0);
            exp_to = to_pat[i];
            model_edge();
            sb.push_back(mk(0, 0, 0, (i == 0) ? 4'd9 : 4'd0, i == 0,
                            (i == 1) ? 4'd9 : 4'd0, i == 1));
            tick();
            got = obs(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL timeout pattern %0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] d  [6] = '{4'd1, 4'd2, 4'd3, 4'd15, 4'd10, 4'd14};
        bit         w  [6] = '{1, 0, 1, 1, 0, 1};
        bit         r  [6] = '{0, 1, 0, 1, 1, 0};
        logic [3:0] md, wd;
        logic       mw, ww;
        rst = 1'b1;
        drive(0, 0, 0, 0, 4'd0, 0, 0);
        model_edge();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 1, d[i], w[i], r[i]);
            md = 4'd0; mw = 1'b0; wd = 4'd0; ww = 1'b0;
            if (i >= 1) begin md = d[i-1]; mw = w[i-1]; end
            if (i >= 2) begin wd = d[i-2]; ww = w[i-2]; end
            model_edge();
            sb.push_back(mk(d[i], w[i], r[i], md, mw, wd, ww));
            tick();
            got = obs(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL back_to_back %0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_stall_counter();
        int n = 0;
        rst = 1'b1;
        drive(0, 0, 0, 0, 4'd0, 0, 0);
        model_edge();
        tick();
        rst = 1'b0;
        drive(0, 0, 1, 0, 4'd0, 0, 0);
        if (SC_EN) begin
            while (exp_sc != 16'hFFFE) begin
                model_edge();
                tick();
                n++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            model_edge();
            n++;
            exp_to = (n >= 3);
            sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
            tick();
            got = obs(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL stall_counter %0d: got %h expected %h", i, got, exp);
            end
        end
        rst = 1'b1;
        drive(0, 0, 0, 0, 4'd0, 0, 0);
        model_edge();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got time limit expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst    = 1'b1;
        exp_to = 1'b0;
        exp_sc = 16'h0000;
        drive(0, 0, 0, 0, 4'd0, 0, 0);
        test_reset();
        test_basic_flow();
        test_load_use();
        test_flush_hazard();
        test_freeze();
        test_timeout();
        test_back_to_back();
        test_stall_counter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
